// File: rtl/alu_result_checker.sv
// Result-side checker for the 8-bit ALU: golden model, expected-result FIFO,
// saturating pass/fail counters, first-mismatch capture and halt-on-fail FSM.
module alu_result_checker #(
  parameter int DEPTH        = 4,
  parameter int CNT_W        = 16,
  parameter bit STOP_ON_FAIL = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       A,
  input  logic [7:0]       B,
  input  logic [2:0]       op,
  input  logic             cin,
  input  logic             res_valid,
  input  logic [7:0]       dut_out,
  input  logic             dut_cout,
  input  logic             dut_c_flag,
  input  logic             dut_zero,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             underflow,
  output logic             halted,
  output logic [22:0]      fail_info
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [7:0] out;
    logic       cout;
    logic       c_flag;
    logic       zero;
  } res_t;

  typedef struct packed {
    logic [2:0] op;
    res_t       r;
  } ent_t;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t state_q, state_d;

  res_t       gold;
  logic [8:0] sum;

  always_comb begin
    gold = '0;
    sum  = '0;
    unique case (op)
      3'b000: begin
        sum = {1'b0, A} + {1'b0, B} + {8'h00, cin};
        {gold.cout, gold.out} = sum;
      end
      3'b001: begin
        sum = {1'b0, A} + {1'b0, ~B} + {8'h00, cin};
        {gold.cout, gold.out} = sum;
      end
      3'b010: gold.out = A & B;
      3'b011: gold.out = A | B;
      3'b100: gold.out = A ^ B;
      3'b101: gold.out = ~A;
      3'b110: begin
        gold.out    = {A[6:0], 1'b0};
        gold.c_flag = A[7];
      end
      3'b111: begin
        gold.out    = {1'b0, A[7:1]};
        gold.c_flag = A[0];
      end
      default: ;
    endcase
    gold.zero = (gold.out == 8'h00);
  end

  ent_t        mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        empty, full;
  logic        push, pop, match;
  ent_t        head;
  res_t        got;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign in_ready = !full && (state_q == RUN);
  assign halted   = (state_q == HALT);

  assign push  = in_valid && in_ready && !clr;
  assign pop   = res_valid && !empty && !clr;
  assign head  = mem[rd_ptr[AW-1:0]];
  assign got   = {dut_out, dut_cout, dut_c_flag, dut_zero};
  assign match = (head.r == got);

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr[AW-1:0]] <= {op, gold};
  end

  always_comb begin
    state_d = state_q;
    if (clr)
      state_d = RUN;
    else if (STOP_ON_FAIL && state_q == RUN && pop && !match)
      state_d = HALT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= RUN;
    else
      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      pass_cnt  <= '0;
      fail_cnt  <= '0;
      underflow <= 1'b0;
      fail_info <= '0;
    end else if (clr) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      pass_cnt  <= '0;
      fail_cnt  <= '0;
      underflow <= 1'b0;
      fail_info <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)
        rd_ptr <= rd_ptr + (AW+1)'(1);
      if (res_valid && empty)
        underflow <= 1'b1;
      if (pop && match && pass_cnt != '1)
        pass_cnt <= pass_cnt + CNT_W'(1);
      if (pop && !match) begin
        if (fail_cnt != '1)
          fail_cnt <= fail_cnt + CNT_W'(1);
        // saturation never returns to zero, so zero means no earlier fail
        if (fail_cnt == '0)
          fail_info <= {head.op, head.r.out, head.r.cout, head.r.c_flag,
                        dut_out, dut_cout, dut_c_flag};
      end
    end
  end

endmodule

// File: tb/tb_alu_result_checker.sv
// Randomized and directed bench for alu_result_checker against a
// queue-based reference model.
module tb_alu_result_checker;

  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clr = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [7:0]       A = '0;
  logic [7:0]       B = '0;
  logic [2:0]       op = '0;
  logic             cin = 1'b0;
  logic             res_valid = 1'b0;
  logic [7:0]       dut_out = '0;
  logic             dut_cout = 1'b0;
  logic             dut_c_flag = 1'b0;
  logic             dut_zero = 1'b0;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] fail_cnt;
  logic             underflow;
  logic             halted;
  logic [22:0]      fail_info;

  alu_result_checker #(
    .DEPTH(DEPTH),
    .CNT_W(CNT_W),
    .STOP_ON_FAIL(1'b1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .clr(clr),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .A(A),
    .B(B),
    .op(op),
    .cin(cin),
    .res_valid(res_valid),
    .dut_out(dut_out),
    .dut_cout(dut_cout),
    .dut_c_flag(dut_c_flag),
    .dut_zero(dut_zero),
    .pass_cnt(pass_cnt),
    .fail_cnt(fail_cnt),
    .underflow(underflow),
    .halted(halted),
    .fail_info(fail_info)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // entries are {op, out, cout, c_flag, zero}
  logic [13:0] m_q[$];
  int          m_pass, m_fail;
  bit          m_under, m_halt;
  logic [22:0] m_info;

  function automatic logic [10:0] ref_alu(int a, int b, logic [2:0] o,
                                          int c);
    int s;
    int out;
    int co;
    int cf;
    s = 0; out = 0; co = 0; cf = 0;
    case (o)
      3'd0: begin s = a + b + c; out = s % 256; co = s / 256; end
      3'd1: begin s = a + (255 - b) + c; out = s % 256; co = s / 256; end
      3'd2: out = a & b;
      3'd3: out = a | b;
      3'd4: out = a ^ b;
      3'd5: out = 255 - a;
      3'd6: begin out = (a * 2) % 256; cf = a / 128; end
      default: begin out = a / 2; cf = a % 2; end
    endcase
    return {8'(out), 1'(co), 1'(cf), 1'(out == 0)};
  endfunction

  function automatic void m_reset();
    m_q.delete();
    m_pass = 0; m_fail = 0;
    m_under = 0; m_halt = 0; m_info = '0;
  endfunction

  function automatic bit m_ready();
    return (m_q.size() < DEPTH) && !m_halt;
  endfunction

  task automatic chk_outs(input string tag);
    chk({tag, ".pass"}, 32'(pass_cnt), 32'(m_pass));
    chk({tag, ".fail"}, 32'(fail_cnt), 32'(m_fail));
    chk({tag, ".under"}, 32'(underflow), 32'(m_under));
    chk({tag, ".halt"}, 32'(halted), 32'(m_halt));
    chk({tag, ".info"}, 32'(fail_info), 32'(m_info));
  endtask

  // One clock: drive at negedge, check ready, advance model at posedge,
  // check registered outputs at next negedge.
  task automatic step(input bit iv, input logic [7:0] a, input logic [7:0] b,
                      input logic [2:0] o, input bit ci, input bit rv,
                      input logic [10:0] flip, input bit ov,
                      input logic [10:0] ovv, input bit c);
    logic [10:0] g;
    logic [13:0] e;
    bit          acc, pp, un;
    if (ov)
      g = ovv;
    else if (m_q.size() > 0)
      g = m_q[0][10:0] ^ flip;
    else
      g = 11'($urandom);
    in_valid = iv; A = a; B = b; op = o; cin = ci;
    res_valid = rv; clr = c;
    {dut_out, dut_cout, dut_c_flag, dut_zero} = g;
    #1;
    chk("in_ready", 32'(in_ready), 32'(m_ready()));
    acc = iv && m_ready() && !c;
    pp  = rv && (m_q.size() > 0) && !c;
    un  = rv && (m_q.size() == 0) && !c;
    @(posedge clk);
    if (c) begin
      m_reset();
    end else begin
      if (pp) begin
        e = m_q.pop_front();
        if (e[10:0] == g) begin
          if (m_pass < 65535) m_pass++;
        end else begin
          if (m_fail == 0)
            m_info = {e[13:11], e[10:1], g[10:1]};
          if (m_fail < 65535) m_fail++;
          m_halt = 1'b1;
        end
      end
      if (un) m_under = 1'b1;
      if (acc) m_q.push_back({o, ref_alu(a, b, o, ci)});
    end
    @(negedge clk);
    chk_outs("step");
  endtask

  task automatic idle_clr();
    step(0, 0, 0, 0, 0, 0, '0, 0, '0, 1);
  endtask

  logic [10:0] tp1 [8];

  initial begin
    tp1[0] = {8'h6D, 1'b0, 1'b0, 1'b0};
    tp1[1] = {8'h51, 1'b1, 1'b0, 1'b0};
    tp1[2] = {8'h0E, 1'b0, 1'b0, 1'b0};
    tp1[3] = {8'h5F, 1'b0, 1'b0, 1'b0};
    tp1[4] = {8'h51, 1'b0, 1'b0, 1'b0};
    tp1[5] = {8'hA0, 1'b0, 1'b0, 1'b0};
    tp1[6] = {8'hBE, 1'b0, 1'b0, 1'b0};
    tp1[7] = {8'h2F, 1'b0, 1'b1, 1'b0};

    m_reset();
    repeat (2) @(negedge clk);
    chk_outs("reset");
    rst_n = 1'b1;

    // all opcodes on A=95 B=14, result one cycle after issue
    for (int i = 0; i <= 8; i++) begin
      logic [2:0] o;
      o = 3'(i);
      step(i < 8, 8'd95, 8'd14, o, o[0], i > 0, '0,
           1, (i > 0) ? tp1[(i + 7) % 8] : 11'h0, 0);
    end
    chk("tp1_pass", 32'(pass_cnt), 32'd8);
    chk("tp1_fail", 32'(fail_cnt), 32'd0);

    // fill the FIFO, 5th issue must be refused
    idle_clr();
    for (int i = 0; i < 5; i++)
      step(1, 8'($urandom), 8'($urandom), 3'($urandom), 1'($urandom),
           0, '0, 0, '0, 0);
    chk("tp2_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 4; i++)
      step(0, 0, 0, 0, 0, 1, '0, 0, '0, 0);
    chk("tp2_pass", 32'(pass_cnt), 32'd4);
    chk("tp2_ready_after", 32'(in_ready), 32'd1);

    // ADD overflow returned with wrong carry
    idle_clr();
    step(1, 8'hFF, 8'h01, 3'b000, 0, 0, '0, 0, '0, 0);
    step(0, 0, 0, 0, 0, 1, 11'h004, 0, '0, 0);
    chk("tp3_fail", 32'(fail_cnt), 32'd1);
    chk("tp3_op", 32'(fail_info[22:20]), 32'd0);
    chk("tp3_info", 32'(fail_info), 32'h000800);
    chk("tp3_halt", 32'(halted), 32'd1);
    chk("tp3_ready", 32'(in_ready), 32'd0);
    idle_clr();
    chk("tp3_clr_halt", 32'(halted), 32'd0);
    chk("tp3_clr_fail", 32'(fail_cnt), 32'd0);

    // result with empty FIFO while a push lands
    step(1, 8'h12, 8'h34, 3'b011, 0, 1, '0, 0, 11'h155, 0);
    chk("tp4_under", 32'(underflow), 32'd1);
    chk("tp4_cnt", 32'(pass_cnt + fail_cnt), 32'd0);
    step(0, 0, 0, 0, 0, 1, '0, 0, '0, 0);
    chk("tp4_pass", 32'(pass_cnt), 32'd1);

    // streaming at occupancy 1
    idle_clr();
    step(1, 8'($urandom), 8'($urandom), 3'($urandom), 1'($urandom),
         0, '0, 0, '0, 0);
    for (int i = 0; i < 20; i++)
      step(1, 8'($urandom), 8'($urandom), 3'($urandom), 1'($urandom),
           1, '0, 0, '0, 0);
    chk("tp5_pass", 32'(pass_cnt), 32'd20);
    chk("tp5_depth", 32'(m_q.size()), 32'd1);
    step(1, 8'h80, 8'h7F, 3'b001, 1, 1, '0, 0, '0, 0);
    #2 rst_n = 1'b0;
    m_reset();
    #1;
    chk_outs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;

    // random traffic with occasional corruption and clears
    for (int i = 0; i < 600; i++) begin
      logic [10:0] fl;
      fl = ($urandom_range(0, 15) == 0) ? 11'($urandom) : 11'h0;
      step(1'($urandom), 8'($urandom), 8'($urandom), 3'($urandom),
           1'($urandom), $urandom_range(0, 2) != 0, fl, 0, '0,
           $urandom_range(0, 40) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
